ofm_write_addr_controller_3: RTL and testbench

Parametrised OFM write-address generator placed between the systolic array output drain and the OFM RAM write port. It walks the output feature map column tile by column tile and row by row. For each output window it issues one write-segment address per channel, or two per channel in 2x upsample mode. Each address goes to the RAM writer through a valid/ready handshake and carries a segment length. All geometry is runtime configuration, latched at `start`.

---
 rtl/ofm_write_addr_controller_3.sv | 200 ++++++++++++++++++++
 tb/tb_ofm_write_addr_controller_3.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_write_addr_controller_3.sv
// OFM write-address generator: walks column tiles and output rows and issues one
// segment address per channel (two in 2x upsample mode) over a valid/ready handshake.
module ofm_write_addr_controller_3 #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int ADDR_W        = 18,
    parameter int DIM_W         = 9,
    parameter int STRIDE_W      = 16,
    parameter int TILE_W        = 14,
    localparam int CW           = $clog2(SYSTOLIC_SIZE) + 1,
    localparam int SW           = $clog2(2 * SYSTOLIC_SIZE) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [STRIDE_W-1:0] cfg_row_stride,
    input  logic [STRIDE_W-1:0] cfg_ch_stride,
    input  logic [DIM_W-1:0]    cfg_ofm_height,
    input  logic [TILE_W-1:0]   cfg_num_col_tiles,
    input  logic [CW-1:0]       cfg_last_seg,
    input  logic                cfg_upsample,
    input  logic                win_valid,
    input  logic [CW-1:0]       win_ch,
    output logic                win_ready,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic [ADDR_W-1:0]   addr,
    output logic [SW-1:0]       seg_len,
    output logic                busy,
    output logic                done
);

    localparam logic [CW-1:0]     S_CW = CW'(SYSTOLIC_SIZE);
    localparam logic [ADDR_W-1:0] S_A  = ADDR_W'(SYSTOLIC_SIZE);
    localparam logic [SW-1:0]     S_SW = SW'(SYSTOLIC_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WIN,
        EMIT,
        ADVANCE,
        DONE
    } state_t;

    state_t              state;

    logic [ADDR_W-1:0]   rs_a;
    logic [ADDR_W-1:0]   cs_a;
    logic                up;
    logic [DIM_W-1:0]    h_m1;
    logic [TILE_W-1:0]   tiles_m1;
    logic [CW-1:0]       last_seg_q;

    logic [DIM_W-1:0]    r;
    logic [TILE_W-1:0]   ct;
    logic [ADDR_W-1:0]   col_base;
    logic [ADDR_W-1:0]   row_addr;
    logic [ADDR_W-1:0]   ch_addr;
    logic [CW-1:0]       ch_idx;
    logic [CW-1:0]       ch_last;
    logic                sub;

    logic [ADDR_W-1:0]   row_step;
    logic [ADDR_W-1:0]   tile_step;
    logic [ADDR_W-1:0]   next_col_base;
    logic [SW-1:0]       seg_base;
    logic [SW-1:0]       seg_next;
    logic                last_row;
    logic                last_tile;

    function automatic logic [CW-1:0] clamp_seg(input logic [CW-1:0] v);
        if (v == '0 || v > S_CW)
            return S_CW;
        return v;
    endfunction

    function automatic logic [CW-1:0] clamp_ch(input logic [CW-1:0] v);
        if (v == '0)
            return CW'(1);
        if (v > S_CW)
            return S_CW;
        return v;
    endfunction

    always_comb begin
        row_step      = up ? (rs_a << 1) : rs_a;
        tile_step     = up ? (S_A << 1) : S_A;
        next_col_base = col_base + tile_step;
        seg_base      = (ct < tiles_m1) ? S_SW : SW'(last_seg_q);
        seg_next      = up ? (seg_base << 1) : seg_base;
        last_row      = (r == h_m1);
        last_tile     = (ct == tiles_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rs_a       <= '0;
            cs_a       <= '0;
            up         <= 1'b0;
            h_m1       <= '0;
            tiles_m1   <= '0;
            last_seg_q <= '0;
            r          <= '0;
            ct         <= '0;
            col_base   <= '0;
            row_addr   <= '0;
            ch_addr    <= '0;
            ch_idx     <= '0;
            ch_last    <= '0;
            sub        <= 1'b0;
            win_ready  <= 1'b0;
            addr_valid <= 1'b0;
            addr       <= '0;
            seg_len    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rs_a       <= ADDR_W'(cfg_row_stride);
                        cs_a       <= ADDR_W'(cfg_ch_stride);
                        up         <= cfg_upsample;
                        h_m1       <= (cfg_ofm_height == '0) ? '0 : cfg_ofm_height - DIM_W'(1);
                        tiles_m1   <= (cfg_num_col_tiles == '0) ? '0 : cfg_num_col_tiles - TILE_W'(1);
                        last_seg_q <= clamp_seg(cfg_last_seg);
                        r          <= '0;
                        ct         <= '0;
                        col_base   <= cfg_base_addr;
                        row_addr   <= cfg_base_addr;
                        busy       <= 1'b1;
                        win_ready  <= 1'b1;
                        state      <= WAIT_WIN;
                    end
                end

                WAIT_WIN: begin
                    if (win_valid) begin
                        ch_last    <= clamp_ch(win_ch) - CW'(1);
                        ch_idx     <= '0;
                        sub        <= 1'b0;
                        ch_addr    <= row_addr;
                        addr       <= row_addr;
                        seg_len    <= seg_next;
                        addr_valid <= 1'b1;
                        win_ready  <= 1'b0;
                        state      <= EMIT;
                    end
                end

                EMIT: begin
                    // ch_addr tracks row_addr + c*CS; the upsampled sub-row adds one RS on top
                    if (addr_ready) begin
                        if (up && !sub) begin
                            sub  <= 1'b1;
                            addr <= ch_addr + rs_a;
                        end else if (ch_idx != ch_last) begin
                            ch_idx  <= ch_idx + CW'(1);
                            sub     <= 1'b0;
                            ch_addr <= ch_addr + cs_a;
                            addr    <= ch_addr + cs_a;
                        end else begin
                            addr_valid <= 1'b0;
                            state      <= ADVANCE;
                        end
                    end
                end

                ADVANCE: begin
                    if (!last_row) begin
                        r        <= r + DIM_W'(1);
                        row_addr <= row_addr + row_step;
                    end else begin
                        r        <= '0;
                        ct       <= ct + TILE_W'(1);
                        col_base <= next_col_base;
                        row_addr <= next_col_base;
                    end
                    if (last_row && last_tile) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        win_ready <= 1'b1;
                        state     <= WAIT_WIN;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_write_addr_controller_3.sv
// Scoreboard bench for ofm_write_addr_controller_3: directed layers push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_ofm_write_addr_controller_3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [17:0] cfg_base_addr = '0;
    logic [15:0] cfg_row_stride = '0;
    logic [15:0] cfg_ch_stride = '0;
    logic [8:0]  cfg_ofm_height = '0;
    logic [13:0] cfg_num_col_tiles = '0;
    logic [4:0]  cfg_last_seg = '0;
    logic        cfg_upsample = 1'b0;
    logic        win_valid = 1'b0;
    logic [4:0]  win_ch = '0;
    logic        win_ready;
    logic        addr_valid;
    logic        addr_ready = 1'b1;
    logic [17:0] addr;
    logic [5:0]  seg_len;
    logic        busy;
    logic        done;

    ofm_write_addr_controller_3 dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride),
        .cfg_ch_stride(cfg_ch_stride), .cfg_ofm_height(cfg_ofm_height),
        .cfg_num_col_tiles(cfg_num_col_tiles), .cfg_last_seg(cfg_last_seg),
        .cfg_upsample(cfg_upsample), .win_valid(win_valid), .win_ch(win_ch),
        .win_ready(win_ready), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr(addr), .seg_len(seg_len), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] a;
        logic [5:0]  s;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    beat_cnt = 0;
    int    wch[8];
    bit    bp_en = 0;
    bit    bp_seen = 0;
    bit    sb_en = 0;

    int unsigned basic_a[12] = '{0, 400, 800, 20, 420, 820, 16, 416, 816, 36, 436, 836};
    int unsigned ups_a[24] = '{0, 40, 400, 440, 800, 840, 80, 120, 480, 520, 880, 920,
                               32, 72, 432, 472, 832, 872, 112, 152, 512, 552, 912, 952};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned a, input int unsigned s);
        beat_t b;
        b.a = 18'(a);
        b.s = 6'(s);
        exp_q.push_back(b);
    endtask

    task automatic push_basic();
        for (int i = 0; i < 12; i++)
            push(basic_a[i], (i < 6) ? 16 : 4);
    endtask

    // Scoreboard monitor: a beat is accepted on the posedge following a negedge with valid & ready
    always @(negedge clk) begin
        if (!rst && addr_valid && addr_ready) begin
            beat_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected beat addr=%0d seg=%0d", addr, seg_len);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (addr !== e.a || seg_len !== e.s) begin
                    errors++;
                    $display("FAIL beat: got addr=%0d seg=%0d expected addr=%0d seg=%0d",
                             addr, seg_len, e.a, e.s);
                end
            end
        end
        if (!rst && done)
            done_cnt++;
    end

    // Backpressure injector: stall beat at address 400 for 5 cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en && addr_valid && addr == 18'd400) begin
                bp_en = 0;
                bp_seen = 1;
                addr_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_hold_valid", 32'(addr_valid), 1);
                    chk("bp_hold_addr", 32'(addr), 400);
                    @(posedge clk);
                    #1;
                end
                addr_ready = 1'b1;
            end
        end
    end

    // Start-while-busy injector: new config and a start pulse mid-EMIT must be ignored
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_en && addr_valid && addr == 18'd400) begin
                sb_en = 0;
                cfg_base_addr = 18'd500;
                cfg_row_stride = 16'd7;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    end

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int budget;
            win_valid = 1'b1;
            win_ch = 5'(wch[i]);
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!win_ready && budget < 1000);
            if (!win_ready) begin
                chk("win_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        win_valid = 1'b0;
    endtask

    task automatic set_cfg(input int unsigned base, input int unsigned rs, input int unsigned cs,
                           input int unsigned h, input int unsigned tiles, input int unsigned last,
                           input bit up);
        cfg_base_addr = 18'(base);
        cfg_row_stride = 16'(rs);
        cfg_ch_stride = 16'(cs);
        cfg_ofm_height = 9'(h);
        cfg_num_col_tiles = 14'(tiles);
        cfg_last_seg = 5'(last);
        cfg_upsample = up;
    endtask

    task automatic run_layer(input string name, input int nwin, input int nbeats);
        int d0;
        int b0;
        int budget;
        d0 = done_cnt;
        b0 = beat_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy_after_start"}, 32'(busy), 1);
        chk({name, "_wready_after_start"}, 32'(win_ready), 1);
        feed(nwin);
        budget = 0;
        while (done_cnt == d0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt - d0), 1);
        @(posedge clk);
        #1;
        chk({name, "_busy_cleared"}, 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
        chk({name, "_beat_count"}, 32'(beat_cnt - b0), 32'(nbeats));
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win_ready", 32'(win_ready), 0);
        chk("rst_addr_valid", 32'(addr_valid), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_seg_len", 32'(seg_len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) wch[i] = 3;

        // Basic layer
        push_basic();
        set_cfg(0, 20, 400, 2, 2, 4, 1'b0);
        run_layer("basic", 4, 12);

        // 2x upsample
        for (int i = 0; i < 24; i++) push(ups_a[i], (i < 12) ? 32 : 8);
        set_cfg(0, 40, 400, 2, 2, 4, 1'b1);
        run_layer("upsample", 4, 24);

        // Backpressure on the second beat
        push_basic();
        set_cfg(0, 20, 400, 2, 2, 4, 1'b0);
        bp_en = 1;
        run_layer("backpressure", 4, 12);
        chk("bp_triggered", 32'(bp_seen), 1);

        // Address wrap, win_ch=0, last_seg=0 and num_col_tiles=0 clamps
        wch[0] = 1;
        wch[1] = 0;
        push(262140, 16);
        push(4, 16);
        set_cfg(262140, 8, 400, 2, 0, 0, 1'b0);
        run_layer("wrap", 2, 2);

        // Oversized win_ch / last_seg and zero height clamps
        wch[0] = 20;
        for (int c = 0; c < 16; c++) push(1000 + 10 * c, 16);
        set_cfg(1000, 5, 10, 0, 1, 20, 1'b0);
        run_layer("clamp_hi", 1, 16);

        // Start pulse while busy is ignored
        for (int i = 0; i < 8; i++) wch[i] = 3;
        push_basic();
        set_cfg(0, 20, 400, 2, 2, 4, 1'b0);
        sb_en = 1;
        run_layer("start_busy", 4, 12);

        // Reset during EMIT of window 1, then replay from the base address
        set_cfg(0, 20, 400, 2, 2, 4, 1'b0);
        push_basic();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        win_valid = 1'b1;
        win_ch = 5'd3;
        budget = 0;
        while (!(addr_valid && addr == 18'd20) && budget < 1000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("rst_mid_reached_win1", 32'(addr), 20);
        rst = 1'b1;
        #1;
        chk("rst_mid_addr_valid", 32'(addr_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_win_ready", 32'(win_ready), 0);
        chk("rst_mid_addr", 32'(addr), 0);
        exp_q.delete();
        win_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_basic();
        run_layer("replay", 4, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
